multi_lane_sender: RTL and testbench
====================================

// Module: multi_lane_sender
// PURPOSE
//  Parametrised N-lane serial packet sender with stop-and-wait reliability. Accepts a
//  packed state snapshot from game logic, slices it across NUM_LANES serial lines,
//  frames each lane with a start bit and retransmits on ACK timeout up to MAX_RETRIES.
//  Holds a one-deep, newest-wins pending buffer so a fresh snapshot is never blocked.
// PARAMETERS
//  NUM_LANES       4    serial data lanes
//  PKT_BITS        836  payload bits per packet
//  LANE_BITS       ceil(PKT_BITS/NUM_LANES)  bits per lane frame (derived, localparam)
//  SEQ_BITS        2    sequence-number width; wraps modulo 2**SEQ_BITS
//  TIMEOUT_CYCLES  200  idle cycles in WAIT_ACK before retransmit
//  MAX_RETRIES     3    retransmits allowed before declaring link failure
// PORTS
//  clk           in   1          single clock for all logic
//  rst_l         in   1          synchronous, active-low reset
//  game_active   in   1          low = abort and hold idle
//  pkt_valid     in   1          1-cycle pulse: pkt_data holds a new snapshot
//  pkt_data      in   PKT_BITS   packet payload
//  ack_received  in   1          1-cycle pulse from receiver
//  ack_seq_num   in   SEQ_BITS   sequence number carried by that ACK
//  serial_out    out  NUM_LANES  one serial bit per lane
//  busy          out  1          high in SEND or WAIT_ACK
//  send_seq_num  out  SEQ_BITS   sequence number of packet in flight / next to send
//  retry_count   out  $clog2(MAX_RETRIES+1)  retransmits of current packet
//  link_fail     out  1          sticky failure flag
// BEHAVIOUR
//  Reset (rst_l==0 at posedge): state=IDLE, serial_out=0, busy=0, send_seq_num=0,
//   retry_count=0, link_fail=0, pending buffer empty.
//  Slicing: payload zero-extended at MSB to NUM_LANES*LANE_BITS; lane 0 carries most
//   significant slice; each lane shifts MSB first.
//  Frame per lane: 1 start bit (1), LANE_BITS data bits, then line returns to 0.
//  States:
//   IDLE: pkt_valid (or pending valid) -> capture into tx register -> SEND.
//    Start bit appears on all lanes the cycle after pkt_valid (latency 1).
//   SEND: LANE_BITS+1 cycles; bit counter reaches LANE_BITS -> WAIT_ACK, timer cleared.
//   WAIT_ACK: timer increments each cycle.
//    ack_received && ack_seq_num==send_seq_num -> send_seq_num++ (wraps),
//     retry_count=0, -> IDLE (pending launches next cycle if valid).
//    Mismatched ack_seq_num: ignored, timer keeps running.
//    timer==TIMEOUT_CYCLES-1 && retry_count<MAX_RETRIES -> retry_count++, resend
//     same tx register and seq -> SEND.
//    timeout with retry_count==MAX_RETRIES -> FAIL.
//    Matching ACK in the same cycle as timeout: ACK wins.
//   FAIL: link_fail=1, serial_out=0; leaves only via game_active low or reset.
//  ACKs in IDLE/SEND/FAIL are ignored.
//  pkt_valid while busy: payload written to pending buffer, overwriting any older
//   pending entry (newest wins). Never stalls; no ready signal.
//  pkt_valid in IDLE with pending valid: new payload sent, pending cleared.
//  game_active low (any state): next cycle state=IDLE, serial_out=0, pending cleared,
//   link_fail cleared, retry_count=0; send_seq_num retained. pkt_valid ignored.
//  Mid-frame reset or abort truncates the frame; no partial-frame completion.
// STRUCTURE
//  NetworkPkg: sender_state_t enum {IDLE,SEND,WAIT_ACK,FAIL}, default parameter
//   constants, LANE_BITS computation function.
//  Sub-module lane_serializer (generated NUM_LANES times): load pulse, LANE_BITS-wide
//   slice in, start-bit + MSB-first shift, single serial bit out.
//  Top level holds FSM, timer, retry counter, seq counter, tx and pending registers.
// TESTING
//  1 Reset then pkt_valid with pkt_data=836'h5A..5A: start bit on all lanes at T+1,
//    lane0 carries bits[835:627] MSB first; 209 data cycles; busy drops on matching ACK.
//  2 No ACK, TIMEOUT_CYCLES=8, MAX_RETRIES=3: exactly 3 identical retransmits with same
//    seq, retry_count 1..3, then link_fail=1 and serial_out held 0.
//  3 ACK with seq 1 while seq 0 in flight: ignored, retransmit at timeout; ACK seq 0
//    -> send_seq_num=1; four packets -> send_seq_num wraps 3->0.
//  4 Two pkt_valid pulses (A then B) during SEND of P: after P's ACK only B is sent,
//    starting 1 cycle after IDLE entry; A never appears on lanes.
//  5 Matching ACK in same cycle as timeout: no retransmit, retry_count=0, IDLE.
//  6 game_active dropped mid-SEND and in FAIL: serial_out=0 next cycle, link_fail=0,
//    pending cleared, send_seq_num unchanged.

Source files
------------

// File: rtl/multi_lane_sender_pkg.sv
// Shared types, default parameter values and lane sizing helper for the
// multi-lane serial packet sender.
package multi_lane_sender_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEND     = 2'd1,
      WAIT_ACK = 2'd2,
      FAIL     = 2'd3
   } sender_state_t;

   localparam int DEF_NUM_LANES      = 4;
   localparam int DEF_PKT_BITS       = 836;
   localparam int DEF_SEQ_BITS       = 2;
   localparam int DEF_TIMEOUT_CYCLES = 200;
   localparam int DEF_MAX_RETRIES    = 3;

   // Bits carried per lane: payload split evenly, rounded up.
   function automatic int lane_bits_f(input int pkt_bits, input int num_lanes);
      return (pkt_bits + num_lanes - 1) / num_lanes;
   endfunction

endpackage

// File: rtl/multi_lane_sender_lane_serializer.sv
// One lane: on load, emits a start bit followed by the slice MSB first,
// then idles at 0. Clear truncates any frame in progress.
module lane_serializer #(
   parameter int LANE_BITS = 209
) (
   input  logic                 clk,
   input  logic                 rst_l,
   input  logic                 clear_i,
   input  logic                 load_i,
   input  logic [LANE_BITS-1:0] slice_i,
   output logic                 serial_o
);

   logic [LANE_BITS:0] shreg_q;
   logic [LANE_BITS:0] shreg_d;

   // Zero fill behind the frame returns the line to 0 after the last bit.
   always_comb begin
      shreg_d = {shreg_q[LANE_BITS-1:0], 1'b0};
      if (clear_i) begin
         shreg_d = '0;
      end else if (load_i) begin
         shreg_d = {1'b1, slice_i};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         shreg_q <= '0;
      end else begin
         shreg_q <= shreg_d;
      end
   end

   assign serial_o = shreg_q[LANE_BITS];

endmodule

// File: rtl/multi_lane_sender.sv
// N-lane stop-and-wait packet sender: slices a snapshot across lanes, waits for
// a sequence-matched ACK, retransmits on timeout, newest-wins pending buffer.
module multi_lane_sender
   import multi_lane_sender_pkg::*;
#(
   parameter int NUM_LANES      = DEF_NUM_LANES,
   parameter int PKT_BITS       = DEF_PKT_BITS,
   parameter int SEQ_BITS       = DEF_SEQ_BITS,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
   input  logic                             clk,
   input  logic                             rst_l,
   input  logic                             game_active,
   input  logic                             pkt_valid,
   input  logic [PKT_BITS-1:0]              pkt_data,
   input  logic                             ack_received,
   input  logic [SEQ_BITS-1:0]              ack_seq_num,
   output logic [NUM_LANES-1:0]             serial_out,
   output logic                             busy,
   output logic [SEQ_BITS-1:0]              send_seq_num,
   output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count,
   output logic                             link_fail,
   output sender_state_t                    dbg_state_o
);

   localparam int LANE_BITS  = lane_bits_f(PKT_BITS, NUM_LANES);
   localparam int TOTAL_BITS = NUM_LANES * LANE_BITS;
   localparam int RW         = $clog2(MAX_RETRIES + 1);
   localparam int TW         = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CW         = $clog2(LANE_BITS + 1);

   sender_state_t       state_q;
   logic [PKT_BITS-1:0] tx_q;
   logic [PKT_BITS-1:0] pend_q;
   logic                pend_valid_q;
   logic [CW-1:0]       bit_cnt_q;
   logic [TW-1:0]       timer_q;
   logic [RW-1:0]       retry_q;
   logic [SEQ_BITS-1:0] seq_q;
   logic                busy_q;
   logic                link_fail_q;

   logic                ack_match;
   logic                timeout;
   logic                launch;
   logic                resend;
   logic                ser_load;
   logic                ser_clear;
   logic [PKT_BITS-1:0] launch_data;
   logic [PKT_BITS-1:0] load_data;
   logic [TOTAL_BITS-1:0] load_padded;

   // A matching ACK takes priority over a timeout landing on the same cycle.
   always_comb begin
      ack_match   = ack_received && (ack_seq_num == seq_q);
      timeout     = (timer_q == TW'(TIMEOUT_CYCLES - 1));
      launch      = game_active && (state_q == IDLE) && (pkt_valid || pend_valid_q);
      launch_data = pkt_valid ? pkt_data : pend_q;
      resend      = game_active && (state_q == WAIT_ACK) && !ack_match && timeout &&
                    (retry_q < RW'(MAX_RETRIES));
      ser_load    = launch || resend;
      ser_clear   = !game_active || (state_q == FAIL);
      load_data   = launch ? launch_data : tx_q;
      load_padded = TOTAL_BITS'(load_data);
   end

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         state_q      <= IDLE;
         tx_q         <= '0;
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         bit_cnt_q    <= '0;
         timer_q      <= '0;
         retry_q      <= '0;
         seq_q        <= '0;
         busy_q       <= 1'b0;
         link_fail_q  <= 1'b0;
      end else if (!game_active) begin
         state_q      <= IDLE;
         pend_valid_q <= 1'b0;
         bit_cnt_q    <= '0;
         timer_q      <= '0;
         retry_q      <= '0;
         busy_q       <= 1'b0;
         link_fail_q  <= 1'b0;
      end else begin
         if (pkt_valid && (state_q == SEND || state_q == WAIT_ACK)) begin
            pend_q       <= pkt_data;
            pend_valid_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (launch) begin
                  tx_q         <= launch_data;
                  pend_valid_q <= 1'b0;
                  bit_cnt_q    <= '0;
                  busy_q       <= 1'b1;
                  state_q      <= SEND;
               end
            end
            SEND: begin
               if (bit_cnt_q == CW'(LANE_BITS)) begin
                  timer_q <= '0;
                  state_q <= WAIT_ACK;
               end else begin
                  bit_cnt_q <= bit_cnt_q + CW'(1);
               end
            end
            WAIT_ACK: begin
               if (ack_match) begin
                  seq_q   <= seq_q + SEQ_BITS'(1);
                  retry_q <= '0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else if (timeout) begin
                  if (resend) begin
                     retry_q   <= retry_q + RW'(1);
                     bit_cnt_q <= '0;
                     state_q   <= SEND;
                  end else begin
                     busy_q      <= 1'b0;
                     link_fail_q <= 1'b1;
                     state_q     <= FAIL;
                  end
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      lane_serializer #(.LANE_BITS(LANE_BITS)) u_ser (
         .clk      (clk),
         .rst_l    (rst_l),
         .clear_i  (ser_clear),
         .load_i   (ser_load),
         .slice_i  (load_padded[TOTAL_BITS-1-l*LANE_BITS -: LANE_BITS]),
         .serial_o (serial_out[l])
      );
   end

   assign busy         = busy_q;
   assign send_seq_num = seq_q;
   assign retry_count  = retry_q;
   assign link_fail    = link_fail_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_multi_lane_sender.sv
// Bench for multi_lane_sender: directed scenarios plus random traffic, all
// outputs compared every cycle against a frame-age model of the sender.
module tb_multi_lane_sender;
   import multi_lane_sender_pkg::*;

   localparam int NL  = 4;
   localparam int PB  = 836;
   localparam int SB  = 2;
   localparam int TO  = 8;
   localparam int MR  = 3;
   localparam int LB  = (PB + NL - 1) / NL;
   localparam int TOT = NL * LB;

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          rst_l = 1'b0;
   logic          game_active = 1'b1;
   logic          pkt_valid = 1'b0;
   logic [PB-1:0] pkt_data = '0;
   logic          ack_received = 1'b0;
   logic [SB-1:0] ack_seq_num = '0;
   logic [NL-1:0] serial_out;
   logic          busy;
   logic [SB-1:0] send_seq_num;
   logic [1:0]    retry_count;
   logic          link_fail;
   sender_state_t dbg_state;

   always #5 clk = ~clk;

   multi_lane_sender #(
      .NUM_LANES(NL), .PKT_BITS(PB), .SEQ_BITS(SB),
      .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)
   ) dut (
      .clk(clk), .rst_l(rst_l), .game_active(game_active),
      .pkt_valid(pkt_valid), .pkt_data(pkt_data),
      .ack_received(ack_received), .ack_seq_num(ack_seq_num),
      .serial_out(serial_out), .busy(busy), .send_seq_num(send_seq_num),
      .retry_count(retry_count), .link_fail(link_fail), .dbg_state_o(dbg_state)
   );

   // ---------------- scoreboard bookkeeping ----------------
   int cmp_cnt = 0;
   int err_cnt = 0;
   logic [PB-1:0] exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic budget_fail(input string name);
      cmp_cnt++;
      err_cnt++;
      $display("FAIL %s: wait budget expired at %0t", name, $time);
   endtask

   // ---------------- behavioural model ----------------
   // Mode 0 idle, 1 link busy, 2 failed. Age counts cycles since the start bit.
   int            m_mode = 0;
   int            m_age = 0;
   int            m_seq = 0;
   int            m_retry = 0;
   bit            m_fail = 0;
   bit            m_pend_v = 0;
   bit            m_init = 0;
   logic [PB-1:0] m_tx = '0;
   logic [PB-1:0] m_pend = '0;

   always @(posedge clk) begin
      if (!rst_l) begin
         m_init = 1; m_mode = 0; m_age = 0; m_seq = 0;
         m_retry = 0; m_fail = 0; m_pend_v = 0;
      end else if (!game_active) begin
         m_mode = 0; m_pend_v = 0; m_fail = 0; m_retry = 0;
      end else begin
         case (m_mode)
            0: if (pkt_valid || m_pend_v) begin
                  m_tx = pkt_valid ? pkt_data : m_pend;
                  m_pend_v = 0; m_mode = 1; m_age = 0;
               end
            1: begin
               if (pkt_valid) begin m_pend = pkt_data; m_pend_v = 1; end
               if (m_age > LB && ack_received && int'(ack_seq_num) == m_seq) begin
                  m_seq = (m_seq + 1) % (1 << SB); m_retry = 0; m_mode = 0;
               end else if (m_age - LB - 1 == TO - 1) begin
                  if (m_retry < MR) begin m_retry++; m_age = 0; end
                  else begin m_mode = 2; m_fail = 1; end
               end else begin
                  m_age++;
               end
            end
            default: ;
         endcase
      end
   end

   function automatic logic [NL-1:0] exp_serial();
      logic [NL-1:0]  r = '0;
      logic [TOT-1:0] p = TOT'(m_tx);
      if (m_mode == 1 && m_age <= LB)
         for (int l = 0; l < NL; l++)
            r[l] = (m_age == 0) ? 1'b1 : p[TOT-1 - l*LB - (m_age-1)];
      return r;
   endfunction

   // Single compare process: every cycle once the model has seen reset.
   always @(negedge clk) begin
      if (m_init) begin
         chk("serial_out",   64'(serial_out),   64'(exp_serial()));
         chk("busy",         64'(busy),         64'(m_mode == 1));
         chk("send_seq_num", 64'(send_seq_num), 64'(m_seq));
         chk("retry_count",  64'(retry_count),  64'(m_retry));
         chk("link_fail",    64'(link_fail),    64'(m_fail));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic send_pkt(input logic [PB-1:0] d);
      pkt_valid = 1'b1; pkt_data = d;
      tick();
      pkt_valid = 1'b0;
   endtask

   task automatic send_ack(input int s);
      ack_received = 1'b1; ack_seq_num = SB'(s);
      tick();
      ack_received = 1'b0;
   endtask

   task automatic wait_model_wait(input string name);
      int n = 0;
      while (!(m_mode == 1 && m_age > LB) && n < 1000) begin tick(); n++; end
      if (n >= 1000) budget_fail(name);
   endtask

   function automatic logic [PB-1:0] rand_pkt();
      logic [32*27-1:0] t;
      for (int i = 0; i < 27; i++) t[i*32 +: 32] = $urandom;
      return t[PB-1:0];
   endfunction

   // ---------------- directed + random stimulus ----------------
   initial begin
      logic [839:0]   pat;
      logic [PB-1:0]  pa, pb, pp;
      logic [TOT-1:0] frame;
      int n, changes, prev, s;

      repeat (3) tick();
      chk("rst_serial", 64'(serial_out), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_seq", 64'(send_seq_num), 64'h0);
      chk("rst_state", 64'(dbg_state), 64'(IDLE));
      rst_l = 1'b1;
      tick();

      // Scenario: 0x5A snapshot, latency and MSB-first slicing pinned by hand.
      pat = {105{8'h5A}};
      send_pkt(pat[PB-1:0]);
      chk("t1_start_bits", 64'(serial_out), 64'hF);
      tick();
      chk("t1_bit0", 64'(serial_out), 64'b0101);
      tick();
      chk("t1_bit1", 64'(serial_out), 64'b0010);
      wait_model_wait("t1_wait");
      send_ack(0);
      chk("t1_busy_after_ack", 64'(busy), 64'h0);
      chk("t1_seq_after_ack", 64'(send_seq_num), 64'h1);

      // Scenario: no ACK at all -> three retransmits then link failure.
      send_pkt(rand_pkt());
      changes = 0; prev = int'(retry_count); n = 0;
      while (m_mode != 2 && n < 2000) begin
         tick(); n++;
         if (int'(retry_count) != prev) begin changes++; prev = int'(retry_count); end
      end
      if (n >= 2000) budget_fail("t2_fail_wait");
      chk("t2_retry_steps", 64'(changes), 64'd3);
      chk("t2_retry_final", 64'(retry_count), 64'd3);
      chk("t2_link_fail", 64'(link_fail), 64'h1);
      chk("t2_state", 64'(dbg_state), 64'(FAIL));
      repeat (5) tick();
      chk("t2_serial_held", 64'(serial_out), 64'h0);
      game_active = 1'b0;
      tick();
      game_active = 1'b1;
      chk("t6_fail_abort_lf", 64'(link_fail), 64'h0);
      chk("t6_fail_abort_seq", 64'(send_seq_num), 64'h1);
      chk("t6_fail_abort_rc", 64'(retry_count), 64'h0);

      // Scenario: stale ACK ignored, correct ACK advances seq, seq wraps.
      send_pkt(rand_pkt());
      wait_model_wait("t3_wait0");
      send_ack(2);
      n = 0;
      while (m_retry != 1 && n < 100) begin tick(); n++; end
      if (n >= 100) budget_fail("t3_retry_wait");
      chk("t3_retry_after_stale", 64'(retry_count), 64'h1);
      wait_model_wait("t3_wait1");
      send_ack(1);
      chk("t3_seq", 64'(send_seq_num), 64'h2);
      s = 2;
      for (int i = 0; i < 4; i++) begin
         send_pkt(rand_pkt());
         wait_model_wait("t3_loop_wait");
         send_ack(s);
         s = (s + 1) % 4;
         chk("t3_seq_loop", 64'(send_seq_num), 64'(s));
      end

      // Scenario: two snapshots during SEND, only the newest goes out.
      pp = rand_pkt(); pa = rand_pkt(); pb = rand_pkt();
      send_pkt(pp);
      repeat (10) tick();
      send_pkt(pa);
      repeat (10) tick();
      send_pkt(pb);
      exp_q.push_back(pb);
      wait_model_wait("t4_wait");
      send_ack(s);
      s = (s + 1) % 4;
      n = 0;
      while (!busy && n < 10) begin tick(); n++; end
      chk("t4_pending_latency", 64'(n), 64'd1);
      chk("t4_start_bits", 64'(serial_out), 64'hF);
      frame = '0;
      for (int k = 0; k < LB; k++) begin
         tick();
         for (int l = 0; l < NL; l++) frame[TOT-1 - l*LB - k] = serial_out[l];
      end
      begin
         logic [PB-1:0] want;
         want = exp_q.pop_front();
         cmp_cnt++;
         if (frame[PB-1:0] !== want) begin
            err_cnt++;
            $display("FAIL t4_frame: got %h expected %h", frame[PB-1:0], want);
         end
      end
      wait_model_wait("t4_wait_b");
      send_ack(s);
      s = (s + 1) % 4;

      // Scenario: matching ACK lands on the timeout cycle.
      send_pkt(rand_pkt());
      wait_model_wait("t5_wait");
      repeat (TO - 1) tick();
      send_ack(s);
      s = (s + 1) % 4;
      chk("t5_retry", 64'(retry_count), 64'h0);
      chk("t5_busy", 64'(busy), 64'h0);
      chk("t5_seq", 64'(send_seq_num), 64'(s));

      // Scenario: abort mid-SEND with a pending snapshot queued.
      send_pkt(rand_pkt());
      repeat (20) tick();
      send_pkt(rand_pkt());
      repeat (5) tick();
      game_active = 1'b0;
      tick();
      game_active = 1'b1;
      chk("t6_send_abort_serial", 64'(serial_out), 64'h0);
      chk("t6_send_abort_busy", 64'(busy), 64'h0);
      chk("t6_send_abort_seq", 64'(send_seq_num), 64'(s));
      repeat (5) tick();
      chk("t6_pending_cleared", 64'(busy), 64'h0);

      // Random traffic against the model.
      for (int c = 0; c < 6000; c++) begin
         game_active  = ($urandom_range(0, 399) != 0);
         pkt_valid    = ($urandom_range(0, 29) == 0);
         if (pkt_valid) pkt_data = rand_pkt();
         ack_received = ($urandom_range(0, 7) == 0);
         ack_seq_num  = ($urandom_range(0, 3) == 0) ? SB'($urandom_range(0, 3)) : SB'(m_seq);
         tick();
      end
      game_active = 1'b1; pkt_valid = 1'b0; ack_received = 1'b0;
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
